seg_display_mux: RTL and testbench

- Parametrised successor to the single-digit 7-segment decoder.
- Time-multiplexes N_DIGITS 4-bit digits onto one shared segment bus with per-digit anode enables, refresh timing, anti-ghosting dead time, leading-zero blanking, HEX/BCD mode and decimal points.
- Sits between the datapath (packed digit value) and the board display pins.

---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg_scan_timer.sv | 51 +++++
 rtl/seg_display_mux.sv | 116 +++++++++++
 tb/tb_seg_display_mux.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, font table and nibble decoder
// for the multiplexed 7-segment display.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_e;

    // Active-high font, bit order {g,f,e,d,c,b,a}
    localparam seg7_t SEG_0    = 7'h3F;
    localparam seg7_t SEG_1    = 7'h06;
    localparam seg7_t SEG_2    = 7'h5B;
    localparam seg7_t SEG_3    = 7'h4F;
    localparam seg7_t SEG_4    = 7'h66;
    localparam seg7_t SEG_5    = 7'h6D;
    localparam seg7_t SEG_6    = 7'h7D;
    localparam seg7_t SEG_7    = 7'h07;
    localparam seg7_t SEG_8    = 7'h7F;
    localparam seg7_t SEG_9    = 7'h6F;
    localparam seg7_t SEG_A    = 7'h77;
    localparam seg7_t SEG_B    = 7'h7C;
    localparam seg7_t SEG_C    = 7'h39;
    localparam seg7_t SEG_D    = 7'h5E;
    localparam seg7_t SEG_E    = 7'h79;
    localparam seg7_t SEG_F    = 7'h71;
    localparam seg7_t SEG_DASH = 7'h40;
    localparam seg7_t SEG_OFF  = 7'h00;

    function automatic seg7_t hex_to_seg(
        input logic [3:0] nibble,
        input logic       hex_mode
    );
        seg7_t s;
        case (nibble)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        if (!hex_mode && nibble > 4'd9) begin
            s = SEG_DASH;
        end
        return s;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Refresh counter, scanned digit index and
// BLANK/DRIVE phase of the current slot.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 2,
    localparam int CW = $clog2(REFRESH_DIV),
    localparam int IW = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_o,
    output phase_e        phase_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        phase_o = PH_DRIVE;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(N_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        // Dead time keeps the old digit from ghosting onto the new anode
        if (32'(cnt_q) < 32'(BLANK_CYC)) begin
            phase_o = PH_BLANK;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed N-digit 7-segment driver with
// shadow register, leading-zero blanking and polarity control.
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYC      = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IW = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic                  load_i,
    input  logic                  hex_mode_i,
    input  logic                  blank_lz_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [IW-1:0]         digit_idx_o
);

    localparam logic [N_DIGITS-1:0] AN_OFF =
        AN_ACTIVE_LOW ? '1 : '0;
    localparam seg7_t SEG_PHY_OFF =
        SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic DP_OFF = SEG_ACTIVE_LOW;

    logic [IW-1:0] idx;
    phase_e        phase;

    seg_scan_timer #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .idx_o   (idx),
        .phase_o (phase)
    );

    logic [4*N_DIGITS-1:0] val_q;
    logic [N_DIGITS-1:0]   dpm_q;
    logic                  hex_q;
    logic                  blz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            dpm_q <= '0;
            hex_q <= 1'b0;
            blz_q <= 1'b0;
        end else if (load_i) begin
            val_q <= value_i;
            dpm_q <= dp_i;
            hex_q <= hex_mode_i;
            blz_q <= blank_lz_i;
        end
    end

    logic [N_DIGITS-1:0] blank_v;
    logic                allz;

    // A digit is blank when it and every digit to its left is zero
    always_comb begin
        blank_v = '0;
        allz    = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            allz       = allz && (val_q[4*k +: 4] == 4'h0);
            blank_v[k] = blz_q && allz;
        end
    end

    logic [N_DIGITS-1:0] an_q, an_d, onehot;
    seg7_t               seg_q, seg_d, seg_raw;
    logic                dp_q, dp_d;

    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_PHY_OFF;
        dp_d    = DP_OFF;
        onehot  = '0;
        seg_raw = SEG_OFF;
        if (phase == PH_DRIVE) begin
            onehot[idx] = 1'b1;
            an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
            if (!blank_v[idx]) begin
                seg_raw = hex_to_seg(val_q[4*idx +: 4], hex_q);
            end
            seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            dp_d  = SEG_ACTIVE_LOW ? ~dpm_q[idx] : dpm_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_PHY_OFF;
            dp_q  <= DP_OFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o        = an_q;
    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign digit_idx_o = idx;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench: 4 digits, 4-cycle slots, 1 blank cycle.
module tb_seg_display_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_i = '0;
    logic        load_i = 1'b0;
    logic        hex_mode_i = 1'b0;
    logic        blank_lz_i = 1'b0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [1:0]  digit_idx_o;

    int n_chk = 0;
    int n_fail = 0;
    int e = 0;

    always #5 clk = ~clk;

    seg_display_mux #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (4),
        .BLANK_CYC      (1),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value_i     (value_i),
        .load_i      (load_i),
        .hex_mode_i  (hex_mode_i),
        .blank_lz_i  (blank_lz_i),
        .dp_i        (dp_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .digit_idx_o (digit_idx_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic goto(input int n);
        while (e < n) step();
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an,
                           input logic [6:0] sg, input logic dp);
        chk({tag, ".an"}, {4'h0, an_o}, {4'h0, an});
        chk({tag, ".seg"}, {1'b0, seg_o}, {1'b0, sg});
        chk({tag, ".dp"}, {7'h0, dp_o}, {7'h0, dp});
    endtask

    // Reset, then load on the first free edge: digit k is driven
    // (with the new contents) in the sample taken after edge 4k+2.
    task automatic load_seq(input logic [15:0] v, input logic [3:0] dp,
                            input logic hex, input logic blz);
        rst = 1'b1;
        step();
        rst = 1'b0;
        e = 0;
        value_i = v;
        dp_i = dp;
        hex_mode_i = hex;
        blank_lz_i = blz;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    initial begin
        // reset held 3 cycles, with a load that must be ignored
        value_i = 16'h8888;
        load_i = 1'b1;
        step();
        step();
        step();
        load_i = 1'b0;
        chk_out("rst", 4'hF, 7'h7F, 1'b1);
        chk("rst.idx", {6'h0, digit_idx_o}, 8'h0);
        rst = 1'b0;
        e = 0;
        step();
        chk("rel1.an", {4'h0, an_o}, 8'h0F);
        step();
        chk_out("rel2", 4'hE, 7'h40, 1'b1);
        chk("rel2.idx", {6'h0, digit_idx_o}, 8'h0);

        // scan order
        load_seq(16'h1234, 4'h0, 1'b1, 1'b0);
        goto(2);
        chk_out("scan.d0", 4'hE, 7'h19, 1'b1);
        goto(5);
        chk_out("scan.blank1", 4'hF, 7'h7F, 1'b1);
        goto(6);
        chk_out("scan.d1", 4'hD, 7'h30, 1'b1);
        chk("scan.idx1", {6'h0, digit_idx_o}, 8'h1);
        goto(10);
        chk_out("scan.d2", 4'hB, 7'h24, 1'b1);
        goto(14);
        chk_out("scan.d3", 4'h7, 7'h79, 1'b1);
        chk("scan.idx3", {6'h0, digit_idx_o}, 8'h3);
        goto(18);
        chk_out("scan.wrap", 4'hE, 7'h19, 1'b1);

        // BCD dash, then hex
        load_seq(16'h00AF, 4'h0, 1'b0, 1'b0);
        goto(2);
        chk("bcd.d0", {1'b0, seg_o}, 8'h3F);
        goto(6);
        chk("bcd.d1", {1'b0, seg_o}, 8'h3F);
        goto(10);
        chk("bcd.d2", {1'b0, seg_o}, 8'h40);
        load_seq(16'h00AF, 4'h0, 1'b1, 1'b0);
        goto(2);
        chk("hex.d0", {1'b0, seg_o}, 8'h0E);
        goto(6);
        chk("hex.d1", {1'b0, seg_o}, 8'h08);

        // leading-zero blanking
        load_seq(16'h0070, 4'b1000, 1'b1, 1'b1);
        goto(2);
        chk_out("lz.d0", 4'hE, 7'h40, 1'b1);
        goto(6);
        chk_out("lz.d1", 4'hD, 7'h78, 1'b1);
        goto(10);
        chk_out("lz.d2", 4'hB, 7'h7F, 1'b1);
        goto(14);
        chk_out("lz.d3", 4'h7, 7'h7F, 1'b0);
        load_seq(16'h0000, 4'h0, 1'b1, 1'b1);
        goto(2);
        chk_out("lz0.d0", 4'hE, 7'h40, 1'b1);
        goto(6);
        chk_out("lz0.d1", 4'hD, 7'h7F, 1'b1);
        goto(14);
        chk("lz0.d3", {1'b0, seg_o}, 8'h7F);

        // load mid-DRIVE of digit 2
        load_seq(16'h1234, 4'h0, 1'b1, 1'b0);
        goto(10);
        value_i = 16'h9999;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
        chk("ld.prior", {1'b0, seg_o}, 8'h24);
        step();
        chk("ld.new", {1'b0, seg_o}, 8'h10);
        chk("ld.an", {4'h0, an_o}, 8'h0B);

        // reset at digit 3, counter 2
        load_seq(16'h1234, 4'h0, 1'b1, 1'b0);
        goto(14);
        chk("mid.idx_pre", {6'h0, digit_idx_o}, 8'h3);
        rst = 1'b1;
        step();
        chk_out("mid.rst", 4'hF, 7'h7F, 1'b1);
        chk("mid.idx", {6'h0, digit_idx_o}, 8'h0);
        rst = 1'b0;
        e = 0;
        goto(2);
        chk_out("mid.d0", 4'hE, 7'h40, 1'b1);
        goto(14);
        chk_out("mid.d3", 4'h7, 7'h40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
